programmable_bus_decoder: RTL and testbench

PROGRAMMABLE_BUS_DECODER -- requirements
Module: programmable_bus_decoder

---
 rtl/programmable_bus_decoder.sv | 192 +++++++++++++++++++
 tb/tb_programmable_bus_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/programmable_bus_decoder.sv
// Programmable 6809 address decoder: NUM_WIN base/mask windows, a 64-byte CSR block,
// an MRDY wait-state stretcher and a sticky unmapped flag. Define DECODER_FAULT_LOG_EN for fault capture.

module programmable_bus_decoder_win #(
  parameter int IDX = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_sel,
  input  logic [7:0] wdata,
  input  logic [7:0] addr_hi,
  input  logic       qual,
  output logic       hit,
  output logic [7:0] base,
  output logic [7:0] mask,
  output logic [7:0] ctrl
);
  localparam logic [7:0] RST_BASE = (IDX == 0) ? 8'h10 : (IDX == 1) ? 8'h30 : 8'h00;
  localparam logic [7:0] RST_MASK = (IDX <= 1) ? 8'hF0 : 8'h00;
  localparam logic [7:0] RST_CTRL = (IDX == 0) ? 8'h80 : (IDX == 1) ? 8'h81 : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base <= RST_BASE;
      mask <= RST_MASK;
      ctrl <= RST_CTRL;
    end else if (wr_en) begin
      case (wr_sel)
        2'd0:    base <= wdata;
        2'd1:    mask <= wdata;
        2'd2:    ctrl <= wdata;
        default: ;
      endcase
    end
  end

  assign hit = qual && ctrl[7] && ((addr_hi & mask) == (base & mask));
endmodule

module programmable_bus_decoder #(
  parameter int          NUM_WIN   = 4,
  parameter logic [15:0] CSR_BASE  = 16'hA040,
  parameter int          FLASH_WIN = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [15:0]        i_address,
  input  logic               i_valid,
  input  logic               i_rw,
  input  logic [7:0]         i_wdata,
  input  logic               i_FT_CS,
  output logic [NUM_WIN-1:0] o_ce,
  output logic               o_csr_sel,
  output logic [7:0]         o_csr_rdata,
  output logic               o_ready,
  output logic               o_unmapped
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt, ws;
  logic prev_valid, start, csr_wr, clr, unmapped_start;
  logic [5:0] off;
  logic [NUM_WIN-1:0] hit;
  logic [NUM_WIN-1:0][7:0] base, mask, ctrl;

  assign off            = i_address[5:0];
  assign o_csr_sel      = i_valid && (i_address[15:6] == CSR_BASE[15:6]);
  assign start          = i_valid && !prev_valid;
  assign csr_wr         = start && o_csr_sel && !i_rw;
  assign clr            = csr_wr && (off == 6'h3F);
  assign unmapped_start = start && !o_csr_sel && !(|hit);

  for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
    localparam bit GATED = (g == FLASH_WIN);
    programmable_bus_decoder_win #(.IDX(g)) u_win (
      .clk     (i_clk),
      .rst_n   (i_reset),
      .wr_en   (csr_wr && (off[5:2] == 4'(g))),
      .wr_sel  (off[1:0]),
      .wdata   (i_wdata),
      .addr_hi (i_address[15:8]),
      .qual    (i_valid && i_reset && (GATED ? i_FT_CS : 1'b1)),
      .hit     (hit[g]),
      .base    (base[g]),
      .mask    (mask[g]),
      .ctrl    (ctrl[g])
    );
  end

  // isolate the lowest set hit bit; CSR decode masks every window
  assign o_ce = o_csr_sel ? '0 : (hit & (~hit + NUM_WIN'(1)));

  always_comb begin
    ws = '0;
    for (int i = 0; i < NUM_WIN; i++)
      if (o_ce[i]) ws = ws | ctrl[i][2:0];
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      prev_valid <= 1'b0;
      o_unmapped <= 1'b0;
    end else begin
      prev_valid <= i_valid;
      if (unmapped_start)  o_unmapped <= 1'b1;
      else if (clr)        o_unmapped <= 1'b0;
    end
  end

`ifdef DECODER_FAULT_LOG_EN
  logic [7:0] fault_hi, fault_lo, fault_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      fault_hi  <= '0;
      fault_lo  <= '0;
      fault_cnt <= '0;
    end else if (unmapped_start) begin
      fault_hi  <= i_address[15:8];
      fault_lo  <= i_address[7:0];
      if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
    end else if (clr) begin
      fault_hi  <= '0;
      fault_lo  <= '0;
      fault_cnt <= '0;
    end
  end
`endif

  always_comb begin
    o_csr_rdata = 8'h00;
    if (o_csr_sel && i_rw) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        if (off[5:2] == 4'(i)) begin
          case (off[1:0])
            2'd0:    o_csr_rdata = base[i];
            2'd1:    o_csr_rdata = mask[i];
            2'd2:    o_csr_rdata = ctrl[i];
            default: o_csr_rdata = 8'h00;
          endcase
        end
      end
`ifdef DECODER_FAULT_LOG_EN
      case (off)
        6'h3C:   o_csr_rdata = fault_hi;
        6'h3D:   o_csr_rdata = fault_lo;
        6'h3E:   o_csr_rdata = fault_cnt;
        default: ;
      endcase
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (start) begin
        if ((|o_ce) && (ws != 3'd0)) begin
          state_nxt = WAIT;
          cnt_nxt   = ws;
        end else begin
          state_nxt = HOLD;
        end
      end
      WAIT: begin
        if (!i_valid)          state_nxt = IDLE;
        else if (cnt == 3'd1)  state_nxt = HOLD;
        else                   cnt_nxt   = cnt - 3'd1;
      end
      HOLD:    if (!i_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ready is a pure decode of registered state, so it never glitches
  always_comb begin
    o_ready = (state != WAIT);
  end
endmodule

// File: tb/tb_programmable_bus_decoder.sv
// Directed bench for programmable_bus_decoder: default windows, CSR programming,
// priority, wait states, unmapped/fault logging, abort and reset behaviour.
module tb_programmable_bus_decoder;
  logic        clk = 0, rst = 0;
  logic [15:0] addr = 0;
  logic        valid = 0, rw = 1, ft_cs = 1;
  logic [7:0]  wdata = 0;
  logic [3:0]  ce;
  logic        csr_sel, ready, unmapped;
  logic [7:0]  rdata;
  int tests = 0, fails = 0;

  programmable_bus_decoder dut (
    .i_clk(clk), .i_reset(rst), .i_address(addr), .i_valid(valid), .i_rw(rw),
    .i_wdata(wdata), .i_FT_CS(ft_cs), .o_ce(ce), .o_csr_sel(csr_sel),
    .o_csr_rdata(rdata), .o_ready(ready), .o_unmapped(unmapped)
  );

  always #5 clk = ~clk;

`ifdef DECODER_FAULT_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  // one bus access: drive at a negedge, capture comb outputs, count ready-low cycles
  task automatic access(input logic [15:0] a, input logic r, input logic [7:0] d, input int hold,
                        output logic [3:0] ce_o, output logic [7:0] rd_o, output logic sel_o,
                        output int low);
    @(negedge clk);
    addr = a; rw = r; wdata = d; valid = 1;
    #1;
    ce_o = ce; rd_o = rdata; sel_o = csr_sel; low = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ready !== 1'b1) low++;
    end
    valid = 0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    logic [3:0] c; logic [7:0] r; logic s; int l;
    access(a, 1'b0, d, 2, c, r, s, l);
  endtask

  task automatic test_reset;
    rst = 0; valid = 1; addr = 16'h1800; rw = 1;
    #12;
    if (ready !== 1'b1) begin $display("FAIL reset_ready got %b want 1", ready); fails++; end tests++;
    if (unmapped !== 1'b0) begin $display("FAIL reset_unmapped got %b want 0", unmapped); fails++; end tests++;
    if (ce !== 4'b0000) begin $display("FAIL reset_ce got %b want 0000", ce); fails++; end tests++;
    @(negedge clk); valid = 0; rst = 1;
    @(negedge clk);
  endtask

  task automatic test_default_windows;
    logic [3:0] c; logic [7:0] r; logic s; int l;
    access(16'h1800, 1, 0, 4, c, r, s, l);
    if (c !== 4'b0001) begin $display("FAIL win0_ce got %b want 0001", c); fails++; end tests++;
    if (l !== 0) begin $display("FAIL win0_low got %0d want 0", l); fails++; end tests++;
    ft_cs = 1;
    access(16'h3400, 1, 0, 4, c, r, s, l);
    if (c !== 4'b0010) begin $display("FAIL win1_ce got %b want 0010", c); fails++; end tests++;
    if (l !== 1) begin $display("FAIL win1_low got %0d want 1", l); fails++; end tests++;
    if (unmapped !== 1'b0) begin $display("FAIL win1_unmapped got %b want 0", unmapped); fails++; end tests++;
    ft_cs = 0;
    access(16'h3400, 1, 0, 3, c, r, s, l);
    ft_cs = 1;
    if (c !== 4'b0000) begin $display("FAIL ftcs_ce got %b want 0000", c); fails++; end tests++;
    if (unmapped !== 1'b1) begin $display("FAIL ftcs_unmapped got %b want 1", unmapped); fails++; end tests++;
    access(16'hA046, 1, 0, 1, c, r, s, l);
    if (r !== 8'h81) begin $display("FAIL rd_win1_ctrl got %h want 81", r); fails++; end tests++;
    access(16'hA041, 1, 0, 1, c, r, s, l);
    if (r !== 8'hF0) begin $display("FAIL rd_win0_mask got %h want f0", r); fails++; end tests++;
    access(16'hA043, 1, 0, 1, c, r, s, l);
    if (r !== 8'h00) begin $display("FAIL rd_off3 got %h want 00", r); fails++; end tests++;
    wr(16'hA07F, 8'h5A);
    if (unmapped !== 1'b0) begin $display("FAIL clear_unmapped got %b want 0", unmapped); fails++; end tests++;
  endtask

  task automatic test_program;
    logic [3:0] c; logic [7:0] r; logic s; int l;
    wr(16'hA048, 8'h50); wr(16'hA049, 8'hFF); wr(16'hA04A, 8'h83);
    access(16'hA04A, 1, 0, 1, c, r, s, l);
    if (r !== 8'h83) begin $display("FAIL rd_win2_ctrl got %h want 83", r); fails++; end tests++;
    access(16'h5012, 1, 0, 6, c, r, s, l);
    if (c !== 4'b0100) begin $display("FAIL win2_ce got %b want 0100", c); fails++; end tests++;
    if (l !== 3) begin $display("FAIL win2_low got %0d want 3", l); fails++; end tests++;
  endtask

  task automatic test_priority;
    logic [3:0] c; logic [7:0] r; logic s; int l;
    wr(16'hA048, 8'h10); wr(16'hA049, 8'hF0);
    access(16'h1000, 1, 0, 3, c, r, s, l);
    if (c !== 4'b0001) begin $display("FAIL overlap_ce got %b want 0001", c); fails++; end tests++;
    if (l !== 0) begin $display("FAIL overlap_low got %0d want 0", l); fails++; end tests++;
    wr(16'hA04C, 8'hA0); wr(16'hA04D, 8'hFF); wr(16'hA04E, 8'h80);
    access(16'hA040, 1, 0, 2, c, r, s, l);
    if (c !== 4'b0000) begin $display("FAIL csr_prio_ce got %b want 0000", c); fails++; end tests++;
    if (s !== 1'b1) begin $display("FAIL csr_prio_sel got %b want 1", s); fails++; end tests++;
    if (r !== 8'h10) begin $display("FAIL csr_prio_rd got %h want 10", r); fails++; end tests++;
  endtask

  task automatic test_fault;
    logic [3:0] c; logic [7:0] r; logic s; int l;
    access(16'hC000, 1, 0, 2, c, r, s, l);
    if (unmapped !== 1'b1) begin $display("FAIL fault_unmapped got %b want 1", unmapped); fails++; end tests++;
    access(16'hA07C, 1, 0, 1, c, r, s, l);
    if (r !== (LOG ? 8'hC0 : 8'h00)) begin $display("FAIL fault_hi got %h want %h", r, LOG ? 8'hC0 : 8'h00); fails++; end tests++;
    access(16'hA07E, 1, 0, 1, c, r, s, l);
    if (r !== (LOG ? 8'h01 : 8'h00)) begin $display("FAIL fault_cnt got %h want %h", r, LOG ? 8'h01 : 8'h00); fails++; end tests++;
    wr(16'hA07F, 8'h00);
    if (unmapped !== 1'b0) begin $display("FAIL fault_clear got %b want 0", unmapped); fails++; end tests++;
    access(16'hA07C, 1, 0, 1, c, r, s, l);
    if (r !== 8'h00) begin $display("FAIL fault_hi_clr got %h want 00", r); fails++; end tests++;
    access(16'hC123, 1, 0, 5, c, r, s, l);
    access(16'hA07D, 1, 0, 1, c, r, s, l);
    if (r !== (LOG ? 8'h23 : 8'h00)) begin $display("FAIL fault_lo got %h want %h", r, LOG ? 8'h23 : 8'h00); fails++; end tests++;
    access(16'hA07E, 1, 0, 1, c, r, s, l);
    if (r !== (LOG ? 8'h01 : 8'h00)) begin $display("FAIL fault_cnt_hold got %h want %h", r, LOG ? 8'h01 : 8'h00); fails++; end tests++;
  endtask

  task automatic test_abort_reset;
    logic [3:0] c; logic [7:0] r; logic s; int l;
    wr(16'hA048, 8'h50); wr(16'hA049, 8'hFF);
    access(16'h5012, 1, 0, 1, c, r, s, l);
    if (l !== 1) begin $display("FAIL abort_low got %0d want 1", l); fails++; end tests++;
    if (ready !== 1'b1) begin $display("FAIL abort_ready got %b want 1", ready); fails++; end tests++;
    @(negedge clk);
    addr = 16'h5012; rw = 1; valid = 1;
    @(negedge clk); @(negedge clk);
    if (ready !== 1'b0) begin $display("FAIL wait_ready got %b want 0", ready); fails++; end tests++;
    rst = 0;
    #1;
    if (ready !== 1'b1) begin $display("FAIL rst_wait_ready got %b want 1", ready); fails++; end tests++;
    if (ce !== 4'b0000) begin $display("FAIL rst_wait_ce got %b want 0000", ce); fails++; end tests++;
    @(negedge clk); valid = 0; rst = 1;
    @(negedge clk);
    if (ready !== 1'b1) begin $display("FAIL post_rst_ready got %b want 1", ready); fails++; end tests++;
    access(16'hA04A, 1, 0, 1, c, r, s, l);
    if (r !== 8'h00) begin $display("FAIL rst_win2_ctrl got %h want 00", r); fails++; end tests++;
    access(16'hA044, 1, 0, 1, c, r, s, l);
    if (r !== 8'h30) begin $display("FAIL rst_win1_base got %h want 30", r); fails++; end tests++;
  endtask

  initial begin
    test_reset;
    test_default_windows;
    test_program;
    test_priority;
    test_fault;
    test_abort_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
